// File: rtl/spi_regfile_pkg.sv
// Shared types and frame-layout helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Total bits in one frame: R/W flag, address, data.
  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  // Bit positions inside a completely shifted-in frame (LSB = last bit received).
  function automatic int rw_pos(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int addr_lsb(input int dw);
    return dw;
  endfunction

  localparam int DATA_LSB = 0;

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between the external controller and the peripheral.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// N-flop synchroniser for an asynchronous pin, with one extra flop for edge pulses.
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [N-1:0] r_sync;
  logic         r_prev;

  // Shift the pin through the sync chain and keep the previous synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {N{RST_LVL}};
      r_prev <= RST_LVL;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_prev <= r_sync[N-1];
    end
  end

  assign o_level = r_sync[N-1];
  assign o_rise  = r_sync[N-1] & ~r_prev;
  assign o_fall  = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 framed write (optional read) front end for a NUM_REGS x DATA_W register bank.
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 8,
  parameter int                NUM_REGS = 5,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_peripheral_if.slave      spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int RW_POS    = rw_pos(ADDR_W, DATA_W);
  localparam int ADDR_LSB  = addr_lsb(DATA_W);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(FRAME_LEN + 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
  logic w_ncs_rise, w_ncs_fall, w_ncs_lvl_unused;
  logic w_copi, w_copi_rise_unused, w_copi_fall_unused;

  // ncs idles high, so its synchroniser resets high to avoid a false frame start.
  spi_sync_edge #(.N(2), .RST_LVL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(spi.sclk),
    .o_level(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_sync_edge #(.N(2), .RST_LVL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(spi.ncs),
    .o_level(w_ncs_lvl_unused), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));
  spi_sync_edge #(.N(2), .RST_LVL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_d(spi.copi),
    .o_level(w_copi), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused));

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_LEN-1:0]  r_shift;
  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic                  r_wr_strobe, r_frame_err;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic                  w_start, w_shift, w_do_write, w_do_err;

  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_addr_ok;

  assign w_rw      = r_shift[RW_POS];
  assign w_addr    = r_shift[ADDR_LSB +: ADDR_W];
  assign w_data    = r_shift[DATA_LSB +: DATA_W];
  assign w_addr_ok = ({{(32-ADDR_W){1'b0}}, w_addr} < 32'(NUM_REGS));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: a frame spans synced ncs fall to synced ncs rise.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ncs_fall) w_state_nxt = SHIFT;
      SHIFT:   if (w_ncs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: frame start, bit capture, and the commit/discard decision at ncs rise.
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_do_write = 1'b0;
    w_do_err   = 1'b0;
    case (r_state)
      IDLE: w_start = w_ncs_fall;
      SHIFT: begin
        if (w_ncs_rise) begin
          if (r_cnt == LEN_C) begin
            w_do_write = w_rw & w_addr_ok;
            w_do_err   = w_rw & ~w_addr_ok;
          end else if (r_cnt != '0) begin
            w_do_err = 1'b1;
          end
        end else begin
          w_shift = w_sclk_rise;
        end
      end
      default: ;
    endcase
  end

  // Bit counter (saturating one past a full frame) and input shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_shift) begin
      r_shift <= {r_shift[FRAME_LEN-2:0], w_copi};
      if (r_cnt != MAX_C) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Register bank commit plus the one-cycle strobe and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RST_VAL;
      r_wr_addr   <= '0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= w_do_write;
      r_frame_err <= w_do_err;
      if (w_do_write) r_wr_addr <= w_addr;
      for (int k = 0; k < NUM_REGS; k++)
        if (w_do_write && (w_addr == ADDR_W'(k))) r_regs[k] <= w_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] RB_C = CNT_W'(1 + ADDR_W);

  logic [DATA_W-1:0] r_tx, w_rb_val;
  logic              r_tx_act;
  logic [ADDR_W-1:0] w_rb_addr;
  logic              w_rb_rw;

  // Once R/W + address are in, they sit in the low bits of the shift register.
  assign w_rb_addr = r_shift[0 +: ADDR_W];
  assign w_rb_rw   = r_shift[ADDR_W];

  // Select the addressed register; out-of-range addresses read as zero.
  always_comb begin
    w_rb_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_rb_addr == ADDR_W'(k)) w_rb_val = r_regs[k];
  end

  // Output shifter: load on the sclk fall after the address, then shift per fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx     <= '0;
      r_tx_act <= 1'b0;
    end else if (r_state == IDLE) begin
      r_tx     <= '0;
      r_tx_act <= 1'b0;
    end else if (w_sclk_fall) begin
      if ((r_cnt == RB_C) && !r_tx_act) begin
        r_tx     <= w_rb_val;
        r_tx_act <= ~w_rb_rw;
      end else if (r_tx_act) begin
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi.cipo = r_tx_act & r_tx[DATA_W-1];
`else
  logic w_sclk_fall_unused;
  assign w_sclk_fall_unused = w_sclk_fall;
  assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench: directed vector table, reset-mid-frame sequence, random frames.
module tb_spi_regfile_peripheral;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int FL       = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_regfile_peripheral_if spi ();

  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;

  spi_regfile_peripheral #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RST_VAL(8'h00)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .spi(spi),
    .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  // Count every cycle the pulses are high; a stuck pulse inflates the count.
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  // Reference model: register array, last write address, expected pulse totals.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [ADDR_W-1:0] m_addr;
  int exp_s = 0;
  int exp_e = 0;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " strobes"}, 32'(strobe_cnt), 32'(exp_s));
    check({tag, " errors"},  32'(err_cnt),    32'(exp_e));
    check({tag, " wr_addr"}, 32'(wr_addr),    32'(m_addr));
    for (int k = 0; k < NUM_REGS; k++)
      check($sformatf("%s reg%0d", tag, k), 32'(regs_o[k*DATA_W +: DATA_W]), 32'(m_regs[k]));
  endtask

  // Apply the frame rules to the model; reports whether a readback value is expected.
  task automatic model_frame(input int n, input logic [31:0] v,
                             output logic chk_rb, output logic [DATA_W-1:0] exp_rb);
    int ai;
    chk_rb = 1'b0;
    exp_rb = '0;
    ai = int'(v[14:8]);
    if (n == 0) return;
    if (n != FL) begin
      exp_e++;
      return;
    end
    if (v[15]) begin
      if (ai < NUM_REGS) begin
        m_regs[ai] = v[7:0];
        m_addr = v[14:8];
        exp_s++;
      end else begin
        exp_e++;
      end
    end else begin
      chk_rb = 1'b1;
`ifdef SPI_READBACK_EN
      if (ai < NUM_REGS) exp_rb = m_regs[ai];
`endif
    end
  endtask

  // Clock out n bits MSB first; capture cipo before each rise of the data phase.
  task automatic shift_bits(input int n, input logic [31:0] v, output logic [DATA_W-1:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi.copi = v[n-1-i];
      wclk(5);
      if (i >= 1 + ADDR_W) rx = {rx[DATA_W-2:0], spi.cipo};
      spi.sclk = 1'b1;
      wclk(5);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] v, input int gap,
                            output logic [DATA_W-1:0] rx);
    spi.ncs = 1'b0;
    wclk(4);
    shift_bits(n, v, rx);
    wclk(4);
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    wclk(gap);
  endtask

  typedef struct {
    int          n;
    logic [31:0] v;
    int          gap;
    int          ds;   // strobes this frame adds
    int          de;   // frame errors this frame adds
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [DATA_W-1:0] rx, exp_rb;
    logic chk_rb;
    int gs, ge, hs, he, n;
    logic [31:0] v;
    bit grp_open;

    tbl[0] = '{16, 32'h82A5, 10, 1, 0};  // write 0xA5 -> reg2
    tbl[1] = '{15, 32'h4152, 10, 0, 1};  // same frame, one bit short
    tbl[2] = '{17, 32'h1054B, 10, 0, 1}; // same frame, one bit long
    tbl[3] = '{16, 32'h873C, 10, 0, 1};  // write to unimplemented address 7
    tbl[4] = '{16, 32'h8011, 2,  1, 0};  // 0x11 -> reg0, 2-clk ncs gap
    tbl[5] = '{16, 32'h8422, 10, 1, 0};  // 0x22 -> reg4
    tbl[6] = '{16, 32'h0200, 10, 0, 0};  // full read of reg2
    tbl[7] = '{9,  32'h0004, 10, 0, 1};  // read frame of wrong length
    tbl[8] = '{0,  32'h0000, 10, 0, 0};  // ncs pulse with no bits

    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_addr = '0;
    spi.ncs = 1'b1; spi.sclk = 1'b0; spi.copi = 1'b0;

    wclk(3);
    check("reset cipo", 32'(spi.cipo), 32'h0);
    check("reset strobe", 32'(wr_strobe), 32'h0);
    check("reset ferr", 32'(frame_err), 32'h0);
    check_state("reset");
    rst_n = 1'b1;
    wclk(5);

    gs = strobe_cnt; ge = err_cnt; hs = 0; he = 0; grp_open = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!grp_open) begin
        gs = strobe_cnt; ge = err_cnt; hs = 0; he = 0;
      end
      send_frame(tbl[i].n, tbl[i].v, tbl[i].gap, rx);
      model_frame(tbl[i].n, tbl[i].v, chk_rb, exp_rb);
      hs += tbl[i].ds;
      he += tbl[i].de;
      grp_open = (tbl[i].gap < 8);
      if (chk_rb) check($sformatf("vec%0d readback", i), 32'(rx), 32'(exp_rb));
      if (!grp_open) begin
        check($sformatf("vec%0d strobe delta", i), 32'(strobe_cnt - gs), 32'(hs));
        check($sformatf("vec%0d error delta", i),  32'(err_cnt - ge),    32'(he));
        check_state($sformatf("vec%0d", i));
      end
    end

    // Reset in the middle of a write to reg1, then a clean write.
    spi.ncs = 1'b0;
    wclk(4);
    shift_bits(9, 32'h815A, rx);
    wclk(2);
    rst_n = 1'b0;
    wclk(2);
    spi.ncs = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_addr = '0;
    check("midreset cipo", 32'(spi.cipo), 32'h0);
    check("midreset strobe", 32'(wr_strobe), 32'h0);
    check_state("midreset");
    wclk(3);
    rst_n = 1'b1;
    wclk(5);
    send_frame(16, 32'h815A, 10, rx);
    model_frame(16, 32'h815A, chk_rb, exp_rb);
    check_state("after reset write");

    // Random frames: mostly full length, addresses spanning legal and illegal.
    for (int it = 0; it < 40; it++) begin
      n = ($urandom_range(0, 9) < 6) ? FL : int'($urandom_range(0, 18));
      v = $urandom;
      v[14:8] = 7'($urandom_range(0, 7));
      send_frame(n, v, 10, rx);
      model_frame(n, v, chk_rb, exp_rb);
      if (chk_rb) check($sformatf("rand%0d readback", it), 32'(rx), 32'(exp_rb));
      check_state($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
